// File: rtl/fetch_unit.sv
// -----------------------------------------------------------------------------
// fetch_unit
//
// Instruction fetch stage for the single-cycle datapath. It owns the fetch PC
// and issues one word read at a time to instruction memory. Returned words are
// stored with their PCs in a small prefetch queue, and the queue head is
// presented to the datapath. A redirect from the datapath flushes the queue and
// restarts fetch at the new target.
//
// Parameters:
//   DEPTH     prefetch queue entries (power of two, >= 2)
//   RESET_PC  fetch address loaded on reset (word aligned)
//
// Ports:
//   clk          clock; all state updates on the rising edge
//   rst          asynchronous active-low reset
//   imem_req     read request, held with imem_addr until imem_ack
//   imem_addr    word address of the outstanding request
//   imem_ack     memory returns imem_rdata this cycle
//   imem_rdata   returned instruction word
//   redirect     one-cycle branch/jump pulse from the datapath
//   redirect_pc  new fetch target, sampled when redirect = 1
//   inst_valid   queue head holds a valid instruction
//   inst         queue head instruction word
//   inst_pc      PC of the queue head instruction
//   inst_ready   datapath consumes the head this cycle
//   misalign     sticky misaligned-redirect flag
//
// Build option:
//   FETCH_ALIGN_CHECK_EN  when defined, a redirect to a non-word-aligned target
//                         sets misalign and halts fetch until reset. When not
//                         defined, the low two target bits are cleared and
//                         misalign is tied to 0.
// -----------------------------------------------------------------------------
module fetch_unit #(
  parameter int          DEPTH    = 2,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        inst_valid,
  output logic [31:0] inst,
  output logic [31:0] inst_pc,
  input  logic        inst_ready,
  output logic        misalign
);

  localparam int            AW   = $clog2(DEPTH);
  localparam logic [AW:0]   FULL = (AW+1)'(DEPTH);

  typedef enum logic [1:0] {
    IDLE,     // no request outstanding
    WAIT,     // request outstanding, data will be queued
    DISCARD   // request outstanding, data will be dropped
  } state_t;

  state_t        state, state_d;
  logic [31:0]   fetch_pc, fetch_pc_d;
  logic [31:0]   addr_d;
  logic [31:0]   target;
  logic [AW:0]   count, count_pp;
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [31:0]   pc_q   [DEPTH];
  logic [31:0]   data_q [DEPTH];
  logic          push, pop, flush;

`ifdef FETCH_ALIGN_CHECK_EN
  logic misalign_q;

  assign target   = redirect_pc;
  assign misalign = misalign_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      misalign_q <= 1'b0;
    else if (redirect && (redirect_pc[1:0] != 2'b00))
      misalign_q <= 1'b1;
  end
`else
  assign target   = redirect_pc & 32'hFFFF_FFFC;
  assign misalign = 1'b0;
`endif

  // A request is outstanding in every state except IDLE.
  assign imem_req   = (state != IDLE);
  assign inst_valid = (count != '0);
  assign inst       = data_q[rd_ptr];
  assign inst_pc    = pc_q[rd_ptr];
  assign pop        = inst_valid & inst_ready;

  // Occupancy after a push in this cycle, accounting for a same-cycle pop.
  assign count_pp = count + {{AW{1'b0}}, 1'b1} - {{AW{1'b0}}, pop};

  always_comb begin
    // NOTE: every signal written here gets a default first, so no path through
    // the case statement can leave one unassigned and infer a latch.
    state_d    = state;
    fetch_pc_d = fetch_pc;
    addr_d     = imem_addr;
    push       = 1'b0;
    flush      = 1'b0;

    if (redirect) begin
      // Redirect overrides push, pop and the normal FSM flow.
      flush      = 1'b1;
      fetch_pc_d = target;
      if (imem_req && !imem_ack)
        state_d = DISCARD;
      else
        state_d = IDLE;
    end else begin
      unique case (state)
        IDLE: begin
          if (count < FULL && !misalign) begin
            state_d = WAIT;
            addr_d  = fetch_pc;
          end
        end
        WAIT: begin
          if (imem_ack) begin
            push       = 1'b1;
            fetch_pc_d = fetch_pc + 32'd4;
            // Chain the next request without a bubble while a slot remains.
            if (count_pp < FULL)
              addr_d = fetch_pc + 32'd4;
            else
              state_d = IDLE;
          end
        end
        DISCARD: begin
          if (imem_ack)
            state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      fetch_pc  <= RESET_PC;
      imem_addr <= RESET_PC;
      count     <= '0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      // NOTE: the queue storage is reset too, because the head is visible on
      // inst/inst_pc and must read as zero out of reset; it is only DEPTH words.
      for (int i = 0; i < DEPTH; i++) begin
        pc_q[i]   <= '0;
        data_q[i] <= '0;
      end
    end else begin
      // NOTE: state registers use non-blocking assignments so every flop
      // samples pre-edge values regardless of statement order.
      state     <= state_d;
      fetch_pc  <= fetch_pc_d;
      imem_addr <= addr_d;
      if (flush) begin
        count  <= '0;
        wr_ptr <= '0;
        rd_ptr <= '0;
      end else begin
        if (push) begin
          pc_q[wr_ptr]   <= fetch_pc;
          data_q[wr_ptr] <= imem_rdata;
          wr_ptr         <= wr_ptr + 1'b1;
        end
        if (pop)
          rd_ptr <= rd_ptr + 1'b1;
        count <= count + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
      end
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// -----------------------------------------------------------------------------
// tb_fetch_unit
//
// Directed bench for fetch_unit (DEPTH=2, RESET_PC=0). A memory responder acks
// each request after a programmable number of cycles and returns a word derived
// from the address; it also logs acked addresses and popped instructions.
// -----------------------------------------------------------------------------
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        inst_valid;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic        inst_ready;
  logic        misalign;

  int n_vec = 0;
  int n_err = 0;
  int lat   = 1;
  int wait_cnt;

  logic [31:0] addr_log [$];
  logic [31:0] pop_pc   [$];
  logic [31:0] pop_inst [$];

  fetch_unit #(.DEPTH(2), .RESET_PC(32'h0000_0000)) dut (
    .clk        (clk),
    .rst        (rst),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_ack   (imem_ack),
    .imem_rdata (imem_rdata),
    .redirect   (redirect),
    .redirect_pc(redirect_pc),
    .inst_valid (inst_valid),
    .inst       (inst),
    .inst_pc    (inst_pc),
    .inst_ready (inst_ready),
    .misalign   (misalign)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] word_at(input logic [31:0] a);
    return a ^ 32'h5EED_0000;
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] log_at(input logic [31:0] q [$], input int i);
    return (i < q.size()) ? q[i] : 32'hDEAD_BEEF;
  endfunction

  // Advance to 1 time unit after the next n rising edges.
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic clear_logs();
    addr_log.delete();
    pop_pc.delete();
    pop_inst.delete();
  endtask

  // Reset for two cycles and release just after a rising edge.
  task automatic do_reset();
    rst         = 1'b0;
    redirect    = 1'b0;
    redirect_pc = 32'h0;
    inst_ready  = 1'b0;
    tick(2);
    clear_logs();
    rst = 1'b1;
  endtask

  // Memory responder and pop monitor, both on the falling edge.
  initial begin
    imem_ack   = 1'b0;
    imem_rdata = 32'h0;
    wait_cnt   = 0;
    forever begin
      @(negedge clk);
      if (rst && imem_req) begin
        wait_cnt++;
        if (wait_cnt >= lat) begin
          imem_ack   = 1'b1;
          imem_rdata = word_at(imem_addr);
          addr_log.push_back(imem_addr);
          wait_cnt   = 0;
        end else begin
          imem_ack = 1'b0;
        end
      end else begin
        imem_ack = 1'b0;
        wait_cnt = 0;
      end
      if (inst_valid && inst_ready) begin
        pop_pc.push_back(inst_pc);
        pop_inst.push_back(inst);
      end
    end
  end

  initial begin
    logic req_seen;

    // Reset state
    lat = 1;
    do_reset();
    rst = 1'b0;
    #1;
    check("rst_req",      {31'h0, imem_req},   32'h0);
    check("rst_addr",     imem_addr,           32'h0);
    check("rst_valid",    {31'h0, inst_valid}, 32'h0);
    check("rst_inst",     inst,                32'h0);
    check("rst_pc",       inst_pc,             32'h0);
    check("rst_misalign", {31'h0, misalign},   32'h0);

    // Streaming fetch, 1-cycle memory, consumer always ready
    lat = 1;
    do_reset();
    inst_ready = 1'b1;
    tick(8);
    check("seq_addr0", log_at(addr_log, 0), 32'h0);
    check("seq_addr1", log_at(addr_log, 1), 32'h4);
    check("seq_addr2", log_at(addr_log, 2), 32'h8);
    check("seq_addr3", log_at(addr_log, 3), 32'hC);
    for (int i = 0; i < 3; i++) begin
      check($sformatf("seq_pc%0d", i),   log_at(pop_pc, i),   32'(i * 4));
      check($sformatf("seq_inst%0d", i), log_at(pop_inst, i), word_at(32'(i * 4)));
    end

    // Queue fills with consumer stalled, then one pop frees a slot
    lat = 1;
    do_reset();
    tick(5);
    check("full_req",   {31'h0, imem_req},   32'h0);
    check("full_valid", {31'h0, inst_valid}, 32'h1);
    check("full_pc",    inst_pc,             32'h0);
    check("full_inst",  inst,                word_at(32'h0));
    inst_ready = 1'b1;
    tick(1);
    inst_ready = 1'b0;
    check("pop_pc",     inst_pc,             32'h4);
    tick(1);
    check("refill_req",  {31'h0, imem_req},  32'h1);
    check("refill_addr", imem_addr,          32'h8);

    // Redirect while a slow request is outstanding
    lat = 3;
    do_reset();
    inst_ready = 1'b1;
    tick(1);
    redirect    = 1'b1;
    redirect_pc = 32'h0000_0400;
    tick(1);
    redirect    = 1'b0;
    check("redir_valid", {31'h0, inst_valid}, 32'h0);
    check("redir_hold_req",  {31'h0, imem_req}, 32'h1);
    check("redir_hold_addr", imem_addr,         32'h0);
    tick(10);
    check("redir_addr0", log_at(addr_log, 0), 32'h0);
    check("redir_addr1", log_at(addr_log, 1), 32'h400);
    check("redir_pc0",   log_at(pop_pc, 0),   32'h400);
    check("redir_inst0", log_at(pop_inst, 0), word_at(32'h400));

    // PC wraps past the top of the address space
    lat = 1;
    do_reset();
    inst_ready  = 1'b1;
    redirect    = 1'b1;
    redirect_pc = 32'hFFFF_FFFC;
    tick(1);
    redirect    = 1'b0;
    tick(5);
    check("wrap_addr0", log_at(addr_log, 0), 32'hFFFF_FFFC);
    check("wrap_addr1", log_at(addr_log, 1), 32'h0);
    check("wrap_pc0",   log_at(pop_pc, 0),   32'hFFFF_FFFC);
    check("wrap_pc1",   log_at(pop_pc, 1),   32'h0);

    // Asynchronous reset in the middle of a request
    lat = 1;
    do_reset();
    tick(2);
    check("mid_req_before", {31'h0, imem_req},   32'h1);
    check("mid_valid_before", {31'h0, inst_valid}, 32'h1);
    #2;
    rst = 1'b0;
    #1;
    check("async_req",   {31'h0, imem_req},   32'h0);
    check("async_valid", {31'h0, inst_valid}, 32'h0);
    check("async_addr",  imem_addr,           32'h0);
    tick(1);
    clear_logs();
    rst        = 1'b1;
    inst_ready = 1'b1;
    tick(4);
    check("restart_addr0", log_at(addr_log, 0), 32'h0);
    check("restart_pc0",   log_at(pop_pc, 0),   32'h0);

    // Misaligned redirect target
    lat = 1;
    do_reset();
    inst_ready  = 1'b1;
    redirect    = 1'b1;
    redirect_pc = 32'h0000_0102;
    tick(1);
    redirect    = 1'b0;
`ifdef FETCH_ALIGN_CHECK_EN
    req_seen = 1'b0;
    for (int i = 0; i < 5; i++) begin
      req_seen = req_seen | imem_req;
      tick(1);
    end
    check("mis_flag",  {31'h0, misalign}, 32'h1);
    check("mis_noreq", {31'h0, req_seen}, 32'h0);
`else
    req_seen = 1'b0;
    tick(5);
    check("mis_flag",  {31'h0, misalign}, 32'h0);
    check("mis_addr0", log_at(addr_log, 0), 32'h100);
    check("mis_pc0",   log_at(pop_pc, 0),   32'h100);
    check("mis_inst0", log_at(pop_inst, 0), word_at(32'h100));
    check("mis_req_unused", {31'h0, req_seen}, 32'h0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction fetch stage that sits directly upstream of the single-cycle datapath.
- Owns the fetch PC and issues word reads to instruction memory over a req/ack handshake.
- Buffers returned words with their PCs in a small prefetch queue and presents them to the datapath with a valid/ready handshake.
- Accepts branch/jump redirects from the datapath, which flush the queue and restart fetch.

Parameters:
- DEPTH, 2, number of prefetch queue entries (power of two, >=2).
- RESET_PC, 32'h00000000, fetch address loaded on reset (word aligned).

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  reset; asynchronous and active-low (0 = reset).
- imem_req  output  1  read request to instruction memory.
- imem_addr  output  32  word address of the request.
- imem_ack  input  1  memory has returned data this cycle.
- imem_rdata  input  32  returned instruction word, valid when imem_ack=1.
- redirect  input  1  datapath branch/jump taken; one-cycle pulse.
- redirect_pc  input  32  new fetch target, sampled when redirect=1.
- inst_valid  output  1  queue head holds a valid instruction.
- inst  output  32  queue head instruction.
- inst_pc  output  32  PC of the queue head instruction.
- inst_ready  input  1  datapath consumes the head this cycle.
- misalign  output  1  sticky misaligned-redirect flag (see Optional Feature).

Behaviour:
- Reset (rst=0, asynchronous): fetch_pc=RESET_PC; queue empty (count=0, pointers 0); state=IDLE; imem_req=0; imem_addr=RESET_PC; inst_valid=0; inst=0; inst_pc=0; misalign=0.
- Only one memory request may be outstanding. Once asserted, imem_req and imem_addr are held stable until the cycle imem_ack=1.
- FSM states:
  - IDLE: if count<DEPTH, assert imem_req with imem_addr=fetch_pc and go to WAIT. Otherwise hold.
  - WAIT: on imem_ack, write {fetch_pc, imem_rdata} at the tail and set fetch_pc=fetch_pc+4. If the post-update count (this push plus any same-cycle pop) is below DEPTH, issue the next request the following cycle with no bubble; remain in WAIT with req high and the new address. Otherwise drop req and go to IDLE.
  - DISCARD: keep req/addr held until imem_ack, drop that data, then go to IDLE.
- Arithmetic: fetch_pc increment is modulo 2^32, so 32'hFFFFFFFC+4 = 32'h00000000.
- Queue: inst_valid = (count!=0); inst/inst_pc show the head combinationally from registers. A pop occurs when inst_valid & inst_ready. Push and pop in the same cycle leaves count unchanged. A push while full cannot occur, because a request is only issued when a slot is free.
- Redirect has priority over push, pop and the FSM:
  - Queue is flushed (count=0) in the same cycle; inst_valid=0 the next cycle.
  - fetch_pc=redirect_pc.
  - If a request is outstanding and imem_ack=0 that cycle, go to DISCARD.
  - If imem_ack=1 that cycle, drop the data and go to IDLE.
  - Otherwise go to IDLE.
  - The first request to the new target appears at the earliest one cycle after redirect.
- A redirect while in DISCARD updates fetch_pc and stays in DISCARD.
- Reset asserted mid-request abandons it immediately. Memory must tolerate a dropped request.

Optional Feature:
- Macro FETCH_ALIGN_CHECK_EN.
- Defined: redirect with redirect_pc[1:0]!=0 sets misalign=1 (sticky until reset), flushes the queue, and stops issuing requests. Any outstanding request still completes and is discarded.
- Undefined: redirect_pc[1:0] is forced to 2'b00, and misalign is tied to 0.

Test Plan:
- Reset release, RESET_PC=0, memory acks each request after 1 cycle, inst_ready=1 -> imem_addr sequence 0,4,8,C; inst_pc follows 0,4,8 with matching words.
- inst_ready=0 with DEPTH=2 -> after two acks: count=2, imem_req=0, inst_pc=0. Raising inst_ready then yields a pop and a new request at addr 8.
- redirect to 32'h00000400 while a request is outstanding (ack 3 cycles later) -> stale data discarded, inst_valid=0, next imem_addr=32'h400, first inst_pc=32'h400.
- fetch_pc=32'hFFFFFFFC acked -> next imem_addr=32'h00000000.
- rst driven low mid-WAIT -> imem_req=0 and inst_valid=0 immediately (asynchronous); after release, fetch restarts at RESET_PC.
- With FETCH_ALIGN_CHECK_EN defined, redirect_pc=32'h102 -> misalign=1, no further imem_req. Undefined -> fetch continues at 32'h100.
